// File: rtl/avg_decimator.sv
// Block-average decimator: sums 2^LOG2_N accepted samples and emits their
// floored mean through a one-entry valid/ready output register.
module avg_decimator #(
    parameter int unsigned LOG2_N = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic signed [15:0] d,
    input  logic               d_valid,
    input  logic               clr,
    output logic signed [15:0] q,
    output logic               q_valid,
    input  logic               q_ready,
    output logic               overrun
);

    localparam int unsigned DW = 16;
    localparam int unsigned AW = DW + LOG2_N;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic signed [AW-1:0]  r_acc;
    logic [LOG2_N-1:0]     r_cnt;
    logic signed [DW-1:0]  r_q;
    logic signed [DW-1:0]  w_q_nxt;
    logic                  r_overrun;
    logic                  w_overrun_nxt;

    logic                  w_accept;
    logic                  w_last;
    logic                  w_complete;
    logic                  w_handshake;
    logic signed [AW-1:0]  w_sum;
    logic signed [DW-1:0]  w_result;

    // Accept/completion decode and running sum including the current sample
    assign w_accept    = d_valid & ~clr;
    assign w_last      = (r_cnt == {LOG2_N{1'b1}});
    assign w_complete  = w_accept & w_last;
    assign w_handshake = (r_state == ST_FULL) & q_ready;
    assign w_sum       = r_acc + {{LOG2_N{d[DW-1]}}, d};
    // Arithmetic shift by LOG2_N then truncate to 16 bits equals the top 16 bits
    assign w_result    = w_sum[AW-1 -: DW];

    // Accumulator and block counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (clr || w_complete) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + LOG2_N'(1);
        end
    end

    // Output register state, data and sticky overrun
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_EMPTY;
            r_q       <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_q       <= w_q_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    // Next-state logic for the EMPTY/FULL output register
    always_comb begin
        w_state_nxt   = r_state;
        w_q_nxt       = r_q;
        w_overrun_nxt = r_overrun;
        case (r_state)
            ST_EMPTY: begin
                if (w_complete) begin
                    w_state_nxt = ST_FULL;
                    w_q_nxt     = w_result;
                end
            end
            ST_FULL: begin
                if (w_complete) begin
                    if (w_handshake) begin
                        w_q_nxt = w_result;
                    end else begin
                        w_overrun_nxt = 1'b1;
                    end
                end else if (w_handshake) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    assign q       = r_q;
    assign q_valid = (r_state == ST_FULL);
    assign overrun = r_overrun;

endmodule
